bundle_sched: RTL and testbench



---
 rtl/bundle_sched_if.sv | 32 +++
 rtl/bundle_sched.sv | 166 ++++++++++++++++
 tb/tb_bundle_sched.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/bundle_sched_if.sv
// Handshake/bus bundle between the bundling sequencer and its neighbours.
// master: core array / DMA side driver; slave: bundle_sched.
interface bundle_sched_if #(
  parameter int NCORE = 4,
  parameter int CNT_W = 30
);
  logic             start;
  logic [CNT_W-1:0] item_num;
  logic [NCORE-1:0] core_valid;
  logic [NCORE-1:0] core_ready;
  logic [NCORE-1:0] store;
  logic             cnt_clr;
  logic             tmp_even;
  logic             stream_v;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;
  logic [31:0]      perf_cycles;

  modport master (
    output start, item_num, core_valid, out_ready,
    input  core_ready, store, cnt_clr, tmp_even,
    input  stream_v, out_valid, busy, done, perf_cycles
  );

  modport slave (
    input  start, item_num, core_valid, out_ready,
    output core_ready, store, cnt_clr, tmp_even,
    output stream_v, out_valid, busy, done, perf_cycles
  );
endinterface

// File: rtl/bundle_sched.sv
// Bundling sequencer: clears the majority-counter bank, grants core results
// into it, injects the even-count tie-break, strobes the output register and
// holds a valid/ready handshake downstream.
// Ports: clk, rst (async, active-high), bus (bundle_sched_if.slave).
// Optional: BUNDLE_SCHED_PERF_EN builds the per-bundle cycle counter.
module bundle_sched #(
  parameter int NCORE = 4,
  parameter int CNT_W = 30,
  parameter int LAT   = 1
) (
  input logic           clk,
  input logic           rst,
  bundle_sched_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, CLEAR, ACCUM, TIE, WAIT, CAPT, HOLD, FIN
  } state_t;

  // Where to go once accumulation (and tie) is finished.
  localparam state_t     POST_TIE = (LAT == 0) ? CAPT : WAIT;
  localparam logic [3:0] LAT_LAST = 4'((LAT == 0) ? 0 : LAT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             even_q, even_d;
  logic [3:0]       wait_cnt_q, wait_cnt_d;

  logic cnt_clr_q;
  logic tmp_even_q;
  logic stream_v_q;
  logic out_valid_q;
  logic busy_q;
  logic done_q;

  logic [NCORE-1:0] store;
  logic [CNT_W-1:0] ngrant;

  // Lowest index first, never more grants than items still owed.
  always_comb begin
    store  = '0;
    ngrant = '0;
    if (state_q == ACCUM) begin
      for (int i = 0; i < NCORE; i++) begin
        if (bus.core_valid[i] && (ngrant < remaining_q)) begin
          store[i] = 1'b1;
          ngrant   = ngrant + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    even_d      = even_q;
    wait_cnt_d  = wait_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.item_num == '0) begin
            state_d = FIN;
          end else begin
            remaining_d = bus.item_num;
            even_d      = ~bus.item_num[0];
            state_d     = CLEAR;
          end
        end
      end
      CLEAR: state_d = ACCUM;
      ACCUM: begin
        remaining_d = remaining_q - ngrant;
        if (remaining_d == '0) begin
          state_d = even_q ? TIE : POST_TIE;
        end
      end
      TIE: state_d = POST_TIE;
      WAIT: begin
        if (wait_cnt_q == LAT_LAST) begin
          wait_cnt_d = '0;
          state_d    = CAPT;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      CAPT: state_d = HOLD;
      HOLD: begin
        if (out_valid_q && bus.out_ready) begin
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered off the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      even_q      <= 1'b0;
      wait_cnt_q  <= '0;
      cnt_clr_q   <= 1'b0;
      tmp_even_q  <= 1'b0;
      stream_v_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      even_q      <= even_d;
      wait_cnt_q  <= wait_cnt_d;
      cnt_clr_q   <= (state_d == CLEAR);
      tmp_even_q  <= (state_d == TIE);
      stream_v_q  <= (state_d == CAPT);
      out_valid_q <= (state_d == HOLD);
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_d == FIN);
    end
  end

  assign bus.store      = store;
  assign bus.core_ready = store;
  assign bus.cnt_clr    = cnt_clr_q;
  assign bus.tmp_even   = tmp_even_q;
  assign bus.stream_v   = stream_v_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

`ifdef BUNDLE_SCHED_PERF_EN
  logic [31:0] perf_cnt_q, perf_cnt_d;
  logic [31:0] perf_q, perf_d;

  // Counts every non-IDLE cycle, FIN included, saturating.
  always_comb begin
    perf_cnt_d = perf_cnt_q;
    perf_d     = perf_q;
    if (state_q == IDLE) begin
      perf_cnt_d = '0;
    end else if (perf_cnt_q != '1) begin
      perf_cnt_d = perf_cnt_q + 32'd1;
    end
    if (state_q == FIN) begin
      perf_d = perf_cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cnt_q <= '0;
      perf_q     <= '0;
    end else begin
      perf_cnt_q <= perf_cnt_d;
      perf_q     <= perf_d;
    end
  end

  assign bus.perf_cycles = perf_q;
`else
  assign bus.perf_cycles = '0;
`endif

endmodule

// File: tb/tb_bundle_sched.sv
// Scoreboard bench for bundle_sched: a phase-level model predicts every
// visible output event; a negedge monitor pops and compares them.
module tb_bundle_sched;

  localparam int NCORE = 4;
  localparam int CNT_W = 30;
  localparam int LAT   = 1;

  typedef struct packed {
    int         cyc;
    logic [3:0] st;
    logic       clr;
    logic       tie;
    logic       sv;
    logic       ov;
    logic       dn;
    logic       bsy;
  } ev_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  ev_t  expq[$];

  bundle_sched_if #(.NCORE(NCORE), .CNT_W(CNT_W)) bus ();

  bundle_sched #(
    .NCORE(NCORE),
    .CNT_W(CNT_W),
    .LAT  (LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Monitor: any active output is an event that must match the model.
  always @(negedge clk) begin
    ev_t a;
    ev_t e;
    if (!rst) begin
      checks++;
      if (bus.core_ready !== bus.store) begin
        errors++;
        $display("FAIL core_ready actual=%b required=%b",
                 bus.core_ready, bus.store);
      end
      checks++;
      if ((32'(bus.store != 0) + 32'(bus.cnt_clr) + 32'(bus.tmp_even)
           + 32'(bus.stream_v)) > 1) begin
        errors++;
        $display("FAIL exclusive actual=%b%b%b%b required=onehot",
                 bus.store != 0, bus.cnt_clr, bus.tmp_even, bus.stream_v);
      end
      a = '{cyc, bus.store, bus.cnt_clr, bus.tmp_even, bus.stream_v,
            bus.out_valid, bus.done, bus.busy};
      if (bus.store != 0 || bus.cnt_clr || bus.tmp_even || bus.stream_v
          || bus.out_valid || bus.done) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event actual=%h required=none", a);
        end else begin
          e = expq.pop_front();
          if (a !== e) begin
            errors++;
            $display("FAIL event actual=%h required=%h", a, e);
          end
        end
      end
    end
  end

  function automatic ev_t mk(input int c, input logic [3:0] st,
                             input logic [4:0] f);
    ev_t e;
    e = '{c, st, f[4], f[3], f[2], f[1], f[0], 1'b1};
    return e;
  endfunction

  // mode 0: all valid, 1: 0101/0000 alternating, 2: random.
  task automatic run_bundle(input int n, input int mode, input int bp);
    logic [3:0] v[$];
    logic [3:0] val;
    logic [3:0] g;
    ev_t        evs[$];
    ev_t        e;
    int         rem, c, k, h, len, t0;
    v   = {};
    evs = {};
    v.push_back(4'($urandom));
    v.push_back(4'($urandom));
    if (n == 0) begin
      evs.push_back(mk(1, 4'b0, 5'b00001));
      h   = 1000;
      len = 2;
    end else begin
      evs.push_back(mk(1, 4'b0, 5'b10000));
      rem = n;
      c   = 2;
      while (rem > 0) begin
        if (mode == 0) val = 4'hF;
        else if (mode == 1) val = (c % 2 == 0) ? 4'b0101 : 4'b0000;
        else val = (c > 30) ? 4'hF : 4'($urandom);
        v.push_back(val);
        g = '0;
        k = 0;
        for (int i = 0; i < NCORE; i++) begin
          if (val[i] && k < rem) begin
            g[i] = 1'b1;
            k++;
          end
        end
        rem -= k;
        if (g != 0) evs.push_back(mk(c, g, 5'b00000));
        c++;
      end
      if (n % 2 == 0) begin
        evs.push_back(mk(c, 4'b0, 5'b01000));
        c++;
      end
      c += LAT;
      evs.push_back(mk(c, 4'b0, 5'b00100));
      c++;
      h = c;
      for (int j = 0; j <= bp; j++) evs.push_back(mk(h + j, 4'b0, 5'b00010));
      evs.push_back(mk(h + bp + 1, 4'b0, 5'b00001));
      len = h + bp + 2;
    end
    t0 = cyc;
    foreach (evs[i]) begin
      e     = evs[i];
      e.cyc = e.cyc + t0;
      expq.push_back(e);
    end
    for (int r = 0; r < len; r++) begin
      bus.start      = (r == 0) || ($urandom_range(0, 3) == 0);
      bus.item_num   = (r == 0) ? CNT_W'(n) : CNT_W'($urandom);
      bus.core_valid = (r < v.size()) ? v[r] : 4'($urandom);
      if (r < h) bus.out_ready = 1'($urandom);
      else bus.out_ready = (r >= h + bp);
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    cyc           = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.item_num  = '0;
    bus.core_valid = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_store", 64'(bus.store), 64'(0));
    chk("rst_ready", 64'(bus.core_ready), 64'(0));
    chk("rst_flags", 64'({bus.cnt_clr, bus.tmp_even, bus.stream_v,
                          bus.out_valid, bus.busy, bus.done}), 64'(0));
    chk("rst_perf", 64'(bus.perf_cycles), 64'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_bundle(7, 0, 0);
`ifdef BUNDLE_SCHED_PERF_EN
    chk("perf_7", 64'(bus.perf_cycles), 64'(6 + LAT));
`else
    chk("perf_off", 64'(bus.perf_cycles), 64'(0));
`endif
    run_bundle(4, 0, 0);
    run_bundle(5, 1, 0);
    run_bundle(3, 0, 5);
    run_bundle(0, 0, 0);
    run_bundle(1, 2, 2);

    // Abort in the middle of accumulation.
    expq.push_back(mk(cyc + 1, 4'b0, 5'b10000));
    bus.start      = 1'b1;
    bus.item_num   = CNT_W'(9);
    bus.core_valid = '0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.core_valid = 4'hF;
    #1;
    chk("accum_store", 64'(bus.store), 64'hF);
    rst = 1'b1;
    #1;
    chk("abort_store", 64'(bus.store), 64'(0));
    chk("abort_flags", 64'({bus.cnt_clr, bus.tmp_even, bus.stream_v,
                            bus.out_valid, bus.busy, bus.done}), 64'(0));
    @(posedge clk);
    #1;
    rst            = 1'b0;
    bus.core_valid = '0;
    run_bundle(3, 0, 0);

    for (int t = 0; t < 30; t++) begin
      run_bundle($urandom_range(0, 12), $urandom_range(0, 2),
                 $urandom_range(0, 5));
`ifndef BUNDLE_SCHED_PERF_EN
      chk("perf_off", 64'(bus.perf_cycles), 64'(0));
`endif
    end

    repeat (4) @(posedge clk);
    #1;
    chk("queue_empty", 64'(expq.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
